pp_decim_coeff_ctrl: RTL and testbench

//  Runtime coefficient configuration controller for the polyphase decimator.

---
 rtl/pp_decim_coeff_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pp_decim_coeff_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_decim_coeff_ctrl.sv
// Runtime coefficient loader for the polyphase decimator: shadow-bank load, phase-aligned swap, flush mute.
// Optional build macro PP_COEFF_CHECKSUM_EN adds a trailing checksum word and the cfg_err pulse.
//
// state | meaning
// IDLE  | waiting for cfg_start
// LOAD  | accepting coefficient words into the shadow bank
// ARMED | full set held, waiting for the last-phase sample to swap
// FLUSH | new bank active, muting output while delay lines refill
module pp_decim_coeff_ctrl #(
    parameter int COEFF_WIDTH   = 16,
    parameter int N_COEFFS      = 3,
    parameter int DECIM_FACTOR  = 2,
    parameter int FLUSH_SAMPLES = 3
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            cfg_start,
    input  logic [COEFF_WIDTH-1:0]          cfg_data,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    output logic                            cfg_busy,
    output logic                            cfg_done,
`ifdef PP_COEFF_CHECKSUM_EN
    output logic                            cfg_err,
`endif
    input  logic                            valid_in,
    input  logic                            bypass_req,
    output logic [N_COEFFS*COEFF_WIDTH-1:0] coeffs,
    output logic                            bypass,
    output logic                            mute
);

    localparam int PH_W = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    localparam int FL_W = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
`ifdef PP_COEFF_CHECKSUM_EN
    localparam int N_WORDS = N_COEFFS + 1;
`else
    localparam int N_WORDS = N_COEFFS;
`endif
    localparam int IDX_W = $clog2(N_WORDS + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM_FACTOR - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_SAMPLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COEFFS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ARMED, FLUSH} state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q;
    logic [PH_W-1:0]                phase_q;
    logic [FL_W-1:0]                flush_cnt_q;
    logic [COEFF_WIDTH-1:0]         shadow_q [N_COEFFS];
    logic [N_COEFFS*COEFF_WIDTH-1:0] active_q;
    logic                           mute_q, done_q, bypass_q;
    logic                           idx_clr, shadow_we, swap, flush_end;
`ifdef PP_COEFF_CHECKSUM_EN
    logic                           ck_fail, err_q;
    logic [COEFF_WIDTH-1:0]         ck_sum;

    always_comb begin
        ck_sum = '0;
        for (int k = 0; k < N_COEFFS; k++) ck_sum = ck_sum + shadow_q[k];
    end
`endif

    always_comb begin
        state_d   = state_q;
        idx_clr   = 1'b0;
        shadow_we = 1'b0;
        swap      = 1'b0;
        flush_end = 1'b0;
`ifdef PP_COEFF_CHECKSUM_EN
        ck_fail   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    idx_clr = 1'b1;
                end
            end
            LOAD: begin
                // a restart beats a coincident handshake; that word is dropped
                if (cfg_start) begin
                    idx_clr = 1'b1;
                end else if (cfg_valid) begin
`ifdef PP_COEFF_CHECKSUM_EN
                    if (idx_q == IDX_W'(N_COEFFS)) begin
                        if (cfg_data == ck_sum) begin
                            state_d = ARMED;
                        end else begin
                            state_d = IDLE;
                            ck_fail = 1'b1;
                        end
                    end else begin
                        shadow_we = 1'b1;
                    end
`else
                    shadow_we = 1'b1;
                    if (idx_q == IDX_LAST) state_d = ARMED;
`endif
                end
            end
            ARMED: begin
                if (valid_in && phase_q == PH_LAST) begin
                    swap    = 1'b1;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (valid_in && flush_cnt_q == FL_LAST) begin
                    flush_end = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            phase_q     <= '0;
            flush_cnt_q <= '0;
            active_q    <= '0;
            mute_q      <= 1'b0;
            done_q      <= 1'b0;
            bypass_q    <= 1'b0;
            for (int k = 0; k < N_COEFFS; k++) shadow_q[k] <= '0;
`ifdef PP_COEFF_CHECKSUM_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bypass_q <= bypass_req;
            done_q   <= flush_end;

            if (idx_clr)        idx_q <= '0;
            else if (shadow_we) idx_q <= idx_q + IDX_W'(1);

            for (int k = 0; k < N_COEFFS; k++) begin
                if (shadow_we && idx_q == IDX_W'(k)) shadow_q[k] <= cfg_data;
            end
`ifdef PP_COEFF_CHECKSUM_EN
            err_q <= ck_fail;
            if (ck_fail) begin
                for (int k = 0; k < N_COEFFS; k++) shadow_q[k] <= '0;
            end
`endif

            if (valid_in) phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);

            if (swap) begin
                for (int k = 0; k < N_COEFFS; k++)
                    active_q[k*COEFF_WIDTH +: COEFF_WIDTH] <= shadow_q[k];
            end

            if (swap)                            flush_cnt_q <= '0;
            else if (state_q == FLUSH && valid_in) flush_cnt_q <= flush_cnt_q + FL_W'(1);

            if (swap)           mute_q <= 1'b1;
            else if (flush_end) mute_q <= 1'b0;
        end
    end

    assign cfg_ready = (state_q == LOAD);
    assign cfg_busy  = (state_q != IDLE);
    assign cfg_done  = done_q;
    assign coeffs    = active_q;
    assign bypass    = bypass_q;
    assign mute      = mute_q;
`ifdef PP_COEFF_CHECKSUM_EN
    assign cfg_err   = err_q;
`endif

endmodule

// File: tb/tb_pp_decim_coeff_ctrl.sv
// Randomised plus directed bench for pp_decim_coeff_ctrl against a transaction-level model.
// Honours PP_COEFF_CHECKSUM_EN the same way as the design.
module tb_pp_decim_coeff_ctrl;

    localparam int W  = 16;
    localparam int N  = 3;
    localparam int DF = 2;
    localparam int FS = 3;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic           cfg_start = 1'b0, cfg_valid = 1'b0, valid_in = 1'b0, bypass_req = 1'b0;
    logic [W-1:0]   cfg_data = '0;
    logic           cfg_ready, cfg_busy, cfg_done, bypass, mute;
    logic [N*W-1:0] coeffs;
`ifdef PP_COEFF_CHECKSUM_EN
    logic           cfg_err;
`endif

    pp_decim_coeff_ctrl #(
        .COEFF_WIDTH(W), .N_COEFFS(N), .DECIM_FACTOR(DF), .FLUSH_SAMPLES(FS)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .cfg_start(cfg_start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
`ifdef PP_COEFF_CHECKSUM_EN
        .cfg_err(cfg_err),
`endif
        .valid_in(valid_in), .bypass_req(bypass_req),
        .coeffs(coeffs), .bypass(bypass), .mute(mute)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: words collected into a shadow list, a pending swap,
    // and a number of samples still to be muted.
    logic [W-1:0] m_active [N];
    logic [W-1:0] m_shadow [N];
    int           m_idx, m_flush_left, m_phase;
    bit           m_loading, m_armed, m_done, m_err, m_bypass;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_active[k] = '0;
            m_shadow[k] = '0;
        end
        m_idx = 0; m_flush_left = 0; m_phase = 0;
        m_loading = 0; m_armed = 0; m_done = 0; m_err = 0; m_bypass = 0;
    endfunction

    function automatic void model_step(bit start, bit valid, logic [W-1:0] data, bit vin, bit breq);
        bit was_idle  = !m_loading && !m_armed && m_flush_left == 0;
        bit was_load  = m_loading;
        bit was_armed = m_armed;
        bit was_flush = m_flush_left > 0;
        logic [W-1:0] sum = '0;
        m_done = 0;
        m_err = 0;
        m_bypass = breq;
        if (was_idle && start) begin
            m_loading = 1;
            m_idx = 0;
        end
        if (was_load) begin
            if (start) begin
                m_idx = 0;
            end else if (valid) begin
                if (m_idx < N) begin
                    m_shadow[m_idx] = data;
                    m_idx++;
`ifndef PP_COEFF_CHECKSUM_EN
                    if (m_idx == N) begin
                        m_loading = 0;
                        m_armed = 1;
                    end
`endif
                end else begin
                    for (int k = 0; k < N; k++) sum += m_shadow[k];
                    m_loading = 0;
                    if (data == sum) m_armed = 1;
                    else begin
                        m_err = 1;
                        for (int k = 0; k < N; k++) m_shadow[k] = '0;
                    end
                end
            end
        end
        if (was_armed && vin && m_phase == DF - 1) begin
            for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
            m_armed = 0;
            m_flush_left = FS;
        end
        if (was_flush && vin) begin
            m_flush_left--;
            if (m_flush_left == 0) m_done = 1;
        end
        if (vin) m_phase = (m_phase + 1) % DF;
    endfunction

    function automatic logic [N*W-1:0] exp_coeffs();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = m_active[k];
        return v;
    endfunction

    task automatic compare_all();
        check("coeffs", coeffs, exp_coeffs());
        check("mute", mute, m_flush_left > 0);
        check("cfg_busy", cfg_busy, m_loading || m_armed || m_flush_left > 0);
        check("cfg_ready", cfg_ready, m_loading);
        check("cfg_done", cfg_done, m_done);
        check("bypass", bypass, m_bypass);
`ifdef PP_COEFF_CHECKSUM_EN
        check("cfg_err", cfg_err, m_err);
`endif
    endtask

    // Called at a falling edge; drives one clock of inputs and checks after the rising edge.
    task automatic cycle(input bit start, input bit valid, input logic [W-1:0] data,
                         input bit vin, input bit breq);
        cfg_start = start; cfg_valid = valid; cfg_data = data;
        valid_in = vin; bypass_req = breq;
        model_step(start, valid, data, vin, breq);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_load(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                           input logic [W-1:0] ck);
        cycle(1, 0, '0, 0, 0);
        cycle(0, 1, w0, 0, 0);
        cycle(0, 1, w1, 0, 0);
        cycle(0, 1, w2, 0, 0);
`ifdef PP_COEFF_CHECKSUM_EN
        cycle(0, 1, ck, 0, 0);
`else
        if (ck != '0) cycle(0, 0, '0, 0, 0);
`endif
    endtask

    // Samples every 4 clocks; cfg_start is pulsed while armed or flushing and must be ignored.
    task automatic run_samples(input int n_clk);
        for (int i = 0; i < n_clk; i++)
            cycle((m_armed || m_flush_left > 0) && (i % 3 == 1), 0, '0, (i % 4) == 3, 0);
    endtask

    task automatic do_reset();
        cfg_start = 0; cfg_valid = 0; valid_in = 0; bypass_req = 1;
        #2 arst_n = 1'b0;
        #1;
        check("rst_coeffs", coeffs, '0);
        check("rst_mute", mute, 1'b0);
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_ready", cfg_ready, 1'b0);
        model_reset();
        @(negedge clk);
        check("rst_bypass", bypass, 1'b0);
        arst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check("init_coeffs", coeffs, '0);
        check("init_busy", cfg_busy, 1'b0);
        check("init_mute", mute, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        compare_all();

        // basic load, swap only after the phase-1 sample
        do_load(16'd1, 16'd2, 16'd3, 16'd6);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, '0, (i % 4) == 3, 0);
            check("pre_swap_hold", coeffs, '0);
        end
        run_samples(24);
        check("dir_load", coeffs, {16'd3, 16'd2, 16'd1});

        // back-pressure: cfg_valid 1,0,1,1
        cycle(1, 0, '0, 0, 0);
        cycle(0, 1, 16'd10, 0, 0);
        cycle(0, 0, 16'd11, 0, 0);
        cycle(0, 1, 16'd12, 0, 0);
        cycle(0, 1, 16'd13, 0, 0);
`ifdef PP_COEFF_CHECKSUM_EN
        cycle(0, 1, 16'd35, 0, 0);
`endif
        run_samples(32);
        check("dir_backpressure", coeffs, {16'd13, 16'd12, 16'd10});

        // restart in LOAD after two words
        cycle(1, 0, '0, 0, 0);
        cycle(0, 1, 16'd20, 0, 0);
        cycle(0, 1, 16'd21, 0, 0);
        cycle(1, 1, 16'd99, 0, 0);
        do_load(16'd22, 16'd23, 16'd24, 16'd69);
        run_samples(32);
        check("dir_restart", coeffs, {16'd24, 16'd23, 16'd22});

        // signed values stored verbatim
        do_load(16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFE);
        run_samples(32);
        check("dir_signed", coeffs, {16'h7FFF, 16'h8000, 16'hFFFF});

`ifdef PP_COEFF_CHECKSUM_EN
        do_load(16'd5, 16'd6, 16'd7, 16'd18);
        run_samples(32);
        check("ck_match", coeffs, {16'd7, 16'd6, 16'd5});
        do_load(16'd8, 16'd9, 16'd10, 16'd19);
        run_samples(32);
        check("ck_mismatch", coeffs, {16'd7, 16'd6, 16'd5});
`endif

        // reset mid-LOAD
        cycle(1, 0, '0, 0, 0);
        cycle(0, 1, 16'd40, 0, 0);
        cycle(0, 1, 16'd41, 0, 0);
        do_reset();
        cycle(0, 0, '0, 0, 1);
        check("post_rst_bypass", bypass, 1'b1);

        // reset mid-FLUSH
        do_load(16'd50, 16'd51, 16'd52, 16'd153);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, 0);
        check("flush_before_rst", mute, 1'b1);
        do_reset();

        // randomised traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if (i == 1100 || i == 2200) do_reset();
            cycle($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), W'($urandom),
                  $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
